// File: rtl/if1_fetch_queue_pkg.sv
// Shared constants, encodings and types for the IF1 fetch queue.
package if1_fetch_queue_pkg;

    localparam logic [31:0] INST_NOP = 32'h0340_0000;
    localparam logic [31:0] PC_RESET = 32'h1C00_0000;

    typedef enum logic [1:0] {
        SER_NONE = 2'b00,
        SER_IBAR = 2'b01,
        SER_CSR  = 2'b10,
        SER_TLB  = 2'b11
    } ser_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EX_IBAR,
        ST_WAIT_CACHE_IDLE,
        ST_WAIT_EX_CSR,
        ST_WAIT_CSR_OK,
        ST_WAIT_EX_TLB,
        ST_WAIT_TLB_OK
    } fq_state_e;

    // Fixed-width packet fields; the top wraps this with the parameter-sized
    // inst/mask/exc fields to form the stored packet.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] badv;
        logic [31:0] cookie;
        logic [1:0]  excp_flag;
    } fq_pkt_hdr_t;

    // Restart PC: the instruction after the serialising slot of the packet.
    function automatic logic [31:0] fq_redirect_pc(input logic [31:0] pc,
                                                   input int unsigned fetch_w,
                                                   input int unsigned slot);
        logic [31:0] base;
        base = pc & ~(32'(fetch_w) * 32'd4 - 32'd1);
        return base + 32'(slot) * 32'd4 + 32'd4;
    endfunction

endpackage

// File: rtl/if1_fq_ser_fsm.sv
// Serialisation FSM: stalls fetch until EX acknowledges the serialising
// instruction and its side effects complete, then pulses a redirect.
module if1_fq_ser_fsm
    import if1_fetch_queue_pkg::*;
#(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned SLOT_W  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              push,
    input  logic [1:0]        ser_kind,
    input  logic [SLOT_W-1:0] ser_slot,
    input  logic [31:0]       in_pc,
    input  logic              ex_ser_ack,
    input  logic              icache_idle,
    input  logic              dcache_idle,
    input  logic              csr_done,
    input  logic              tlb_done,
    output logic              idle,
    output logic              fetch_kill,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc
);

    fq_state_e   state;
    fq_state_e   state_nx;
    logic        redirect_nx;
    logic [31:0] slot_idx;

    assign slot_idx = (FETCH_W > 1) ? 32'(ser_slot) : 32'd0;
    assign idle     = (state == ST_IDLE);

    // State register, registered redirect pulse and latched restart PC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (flush) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nx;
            redirect_valid <= redirect_nx;
            if (push && (ser_kind != SER_NONE))
                redirect_pc <= fq_redirect_pc(in_pc, FETCH_W, slot_idx);
        end
    end

    // Next-state, fetch kill and redirect request.
    always_comb begin
        state_nx    = state;
        redirect_nx = 1'b0;
        fetch_kill  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (push) begin
                    unique case (ser_kind)
                        SER_IBAR: state_nx = ST_WAIT_EX_IBAR;
                        SER_CSR:  state_nx = ST_WAIT_EX_CSR;
                        SER_TLB:  state_nx = ST_WAIT_EX_TLB;
                        default:  state_nx = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT_EX_IBAR: begin
                fetch_kill = 1'b1;
                if (ex_ser_ack) state_nx = ST_WAIT_CACHE_IDLE;
            end
            ST_WAIT_CACHE_IDLE: begin
                if (icache_idle && dcache_idle) begin
                    state_nx    = ST_IDLE;
                    redirect_nx = 1'b1;
                end
            end
            ST_WAIT_EX_CSR: begin
                fetch_kill = 1'b1;
                if (ex_ser_ack) state_nx = ST_WAIT_CSR_OK;
            end
            ST_WAIT_CSR_OK: begin
                if (csr_done) begin
                    state_nx    = ST_IDLE;
                    redirect_nx = 1'b1;
                end
            end
            ST_WAIT_EX_TLB: begin
                fetch_kill = 1'b1;
                if (ex_ser_ack) state_nx = ST_WAIT_TLB_OK;
            end
            ST_WAIT_TLB_OK: begin
                if (tlb_done) begin
                    state_nx    = ST_IDLE;
                    redirect_nx = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/if1_fetch_queue.sv
// IF1 -> decode fetch-packet queue with per-slot masking and serialisation
// stall. Optional macro IF1_FQ_BYPASS_EN forwards a push straight to the
// output when the queue is empty.
module if1_fetch_queue
    import if1_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned EXC_W   = 7
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_pc_next,
    input  logic [FETCH_W*32-1:0]      in_inst,
    input  logic [31:0]                in_badv,
    input  logic [EXC_W-1:0]           in_exc,
    input  logic [1:0]                 in_excp_flag,
    input  logic [31:0]                in_cookie,
    input  logic [1:0]                 ser_kind,
    input  logic [((FETCH_W > 1) ? $clog2(FETCH_W) : 1)-1:0] ser_slot,
    input  logic                       ex_ser_ack,
    input  logic                       icache_idle,
    input  logic                       dcache_idle,
    input  logic                       csr_done,
    input  logic                       tlb_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc_next,
    output logic [31:0]                out_badv,
    output logic [31:0]                out_cookie,
    output logic [FETCH_W*32-1:0]      out_inst,
    output logic [FETCH_W-1:0]         out_mask,
    output logic [EXC_W-1:0]           out_exc,
    output logic [1:0]                 out_excp_flag,
    output logic                       fetch_kill,
    output logic                       redirect_valid,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        fq_pkt_hdr_t             hdr;
        logic [FETCH_W*32-1:0]   inst;
        logic [FETCH_W-1:0]      mask;
        logic [EXC_W-1:0]        exc;
    } pkt_t;

    pkt_t             mem [DEPTH];
    pkt_t             in_pkt;
    pkt_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             fsm_idle;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      align_idx;
    logic [31:0]      ser_idx;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = !full && fsm_idle && !flush;
    assign push     = in_valid && in_ready;

`ifdef IF1_FQ_BYPASS_EN
    assign bypass = empty && push;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty || bypass;
    assign pop       = out_valid && out_ready;
    // A bypassed packet consumed in the same cycle never touches storage.
    assign wr_en     = push && !(bypass && pop);
    assign rd_en     = pop && !bypass;

    assign align_idx = (in_pc >> 2) & 32'(FETCH_W - 1);
    assign ser_idx   = (FETCH_W > 1) ? 32'(ser_slot) : 32'd0;

    // Build the stored packet: clear slots before the PC and after a serialiser.
    always_comb begin
        in_pkt               = '0;
        in_pkt.hdr.pc        = in_pc;
        in_pkt.hdr.pc_next   = in_pc_next;
        in_pkt.hdr.badv      = in_badv;
        in_pkt.hdr.cookie    = in_cookie;
        in_pkt.exc           = in_exc;
        in_pkt.hdr.excp_flag = ((ser_kind != SER_NONE) && (ser_idx < align_idx)) ?
                               2'b00 : in_excp_flag;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            in_pkt.mask[i] = (i >= align_idx) && ((ser_kind == SER_NONE) || (i <= ser_idx));
            in_pkt.inst[32*i +: 32] = in_pkt.mask[i] ? in_inst[32*i +: 32] : INST_NOP;
        end
    end

    // Head view: reset values when empty, else the oldest stored packet.
    always_comb begin
        head        = '0;
        head.hdr.pc = PC_RESET;
        head.inst   = {FETCH_W{INST_NOP}};
        if (bypass)
            head = in_pkt;
        else if (!empty)
            head = mem[rd_ptr];
    end

    assign out_pc        = head.hdr.pc;
    assign out_pc_next   = head.hdr.pc_next;
    assign out_badv      = head.hdr.badv;
    assign out_cookie    = head.hdr.cookie;
    assign out_excp_flag = head.hdr.excp_flag;
    assign out_inst      = head.inst;
    assign out_mask      = head.mask;
    assign out_exc       = head.exc;

    // Packet storage write port.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_pkt;
    end

    // Pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    if1_fq_ser_fsm #(
        .FETCH_W (FETCH_W),
        .SLOT_W  (SLOT_W)
    ) u_ser_fsm (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .push           (push),
        .ser_kind       (ser_kind),
        .ser_slot       (ser_slot),
        .in_pc          (in_pc),
        .ex_ser_ack     (ex_ser_ack),
        .icache_idle    (icache_idle),
        .dcache_idle    (dcache_idle),
        .csr_done       (csr_done),
        .tlb_done       (tlb_done),
        .idle           (fsm_idle),
        .fetch_kill     (fetch_kill),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

endmodule

// File: tb/tb_if1_fetch_queue.sv
// Self-checking bench for if1_fetch_queue (default build, FETCH_W=2, DEPTH=4).
`timescale 1ns/1ps
module tb_if1_fetch_queue;

    localparam int DEPTH = 4;
    localparam int FW    = 2;
    localparam int EXC_W = 7;
    localparam logic [31:0] NOP = 32'h0340_0000;
    localparam logic [31:0] PCR = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush, in_valid, ex_ser_ack, icache_idle, dcache_idle;
    logic        csr_done, tlb_done, out_ready;
    logic [31:0] in_pc, in_pc_next, in_badv, in_cookie;
    logic [63:0] in_inst;
    logic [6:0]  in_exc;
    logic [1:0]  in_excp_flag, ser_kind;
    logic        ser_slot;
    logic        in_ready, out_valid, fetch_kill, redirect_valid;
    logic [31:0] out_pc, out_pc_next, out_badv, out_cookie, redirect_pc;
    logic [63:0] out_inst;
    logic [1:0]  out_mask, out_excp_flag;
    logic [6:0]  out_exc;
    logic [2:0]  count;
    logic [63:0] nop_pair;

    always #5 clk = ~clk;

    if1_fetch_queue #(.DEPTH(DEPTH), .FETCH_W(FW), .EXC_W(EXC_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_pc_next(in_pc_next),
        .in_inst(in_inst), .in_badv(in_badv), .in_exc(in_exc), .in_excp_flag(in_excp_flag),
        .in_cookie(in_cookie), .ser_kind(ser_kind), .ser_slot(ser_slot),
        .ex_ser_ack(ex_ser_ack), .icache_idle(icache_idle), .dcache_idle(dcache_idle),
        .csr_done(csr_done), .tlb_done(tlb_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc_next(out_pc_next),
        .out_badv(out_badv), .out_cookie(out_cookie), .out_inst(out_inst), .out_mask(out_mask),
        .out_exc(out_exc), .out_excp_flag(out_excp_flag), .fetch_kill(fetch_kill),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .count(count)
    );

    typedef struct {
        logic [31:0] pc, pc_next, badv, cookie;
        logic [63:0] inst;
        logic [1:0]  mask;
        logic [6:0]  exc;
        logic [1:0]  flag;
    } pkt_t;

    // Reference model state: queued packets plus the pending serialisation.
    pkt_t        q[$];
    int          pend_kind = 0;
    bit          acked = 0;
    bit          exp_redir = 0;
    logic [31:0] exp_rpc = '0;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pkt_t build();
        pkt_t p;
        int a;
        a = int'(in_pc / 4) % FW;
        p.pc = in_pc; p.pc_next = in_pc_next; p.badv = in_badv; p.cookie = in_cookie;
        p.exc = in_exc; p.flag = in_excp_flag;
        for (int i = 0; i < FW; i++) begin
            bit keep;
            keep = (i >= a) && (ser_kind == 0 || i <= int'(ser_slot));
            p.mask[i] = keep;
            p.inst[32*i +: 32] = keep ? in_inst[32*i +: 32] : NOP;
        end
        if (ser_kind != 0 && int'(ser_slot) < a) p.flag = 2'b00;
        return p;
    endfunction

    // Behavioural model update on each clock edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete(); pend_kind = 0; acked = 0; exp_redir = 0; exp_rpc = '0;
        end else if (flush) begin
            q.delete(); pend_kind = 0; acked = 0; exp_redir = 0; exp_rpc = '0;
        end else begin
            bit do_push, do_pop, nredir;
            do_push = in_valid && q.size() < DEPTH && pend_kind == 0;
            do_pop  = out_ready && q.size() != 0;
            nredir  = 0;
            if (pend_kind != 0) begin
                if (!acked) acked = ex_ser_ack;
                else if ((pend_kind == 1 && icache_idle && dcache_idle) ||
                         (pend_kind == 2 && csr_done) || (pend_kind == 3 && tlb_done)) begin
                    pend_kind = 0;
                    nredir = 1;
                end
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(build());
                if (ser_kind != 0) begin
                    pend_kind = int'(ser_kind);
                    acked = 0;
                    exp_rpc = (in_pc / (FW * 4)) * (FW * 4) + 32'(ser_slot) * 4 + 4;
                end
            end
            exp_redir = nredir;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && rstn) begin
            chk("in_ready", in_ready, q.size() < DEPTH && pend_kind == 0 && !flush);
            chk("out_valid", out_valid, q.size() != 0);
            chk("count", count, q.size());
            chk("fetch_kill", fetch_kill, pend_kind != 0 && !acked);
            chk("redirect_valid", redirect_valid, exp_redir);
            if (exp_redir) chk("redirect_pc", redirect_pc, exp_rpc);
            if (q.size() != 0) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_pc_next", out_pc_next, q[0].pc_next);
                chk("out_badv", out_badv, q[0].badv);
                chk("out_cookie", out_cookie, q[0].cookie);
                chk("out_inst", out_inst, q[0].inst);
                chk("out_mask", out_mask, q[0].mask);
                chk("out_exc", out_exc, q[0].exc);
                chk("out_excp_flag", out_excp_flag, q[0].flag);
            end
        end
    end

    task automatic idle_in();
        in_valid = 0; flush = 0; out_ready = 0; ser_kind = 0; ser_slot = 0;
        ex_ser_ack = 0; icache_idle = 0; dcache_idle = 0; csr_done = 0; tlb_done = 0;
    endtask

    task automatic set_pkt(input logic [31:0] pc, input logic [1:0] k, input logic s);
        in_pc = pc; in_pc_next = pc + 8; in_inst = {$urandom(), $urandom()};
        in_badv = $urandom(); in_exc = 7'($urandom()); in_excp_flag = 2'($urandom());
        in_cookie = $urandom(); ser_kind = k; ser_slot = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nop_pair = {NOP, NOP};
        idle_in();
        set_pkt(32'h0, 2'b00, 1'b0);
        rstn = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        chk_en = 1;

        // Reset values
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, PCR);
        chk("rst_out_inst", out_inst, nop_pair);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_fetch_kill", fetch_kill, 0);
        chk("rst_redirect", redirect_valid, 0);

        // Fill to full, then drain with continuous pushes
        for (int k = 0; k < 5; k++) begin
            set_pkt(32'h100 + 8 * k, 2'b00, 1'b0);
            in_valid = 1;
            step();
        end
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_head", out_pc, 32'h100);
        step();
        out_ready = 1;
        for (int j = 0; j < 4; j++) begin
            set_pkt(32'h200 + 8 * j, 2'b00, 1'b0);
            in_valid = 1;
            @(negedge clk);
            chk("order", out_pc, 32'h100 + 8 * j);
            step();
        end
        in_valid = 0;
        @(negedge clk);
        chk("wrap_count", count, 3);
        chk("wrap_head", out_pc, 32'h208);
        repeat (4) step();

        // Misaligned PC
        out_ready = 0;
        set_pkt(32'h1C00_0004, 2'b00, 1'b0);
        in_valid = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("misalign_mask", out_mask, 2'b10);
        chk("misalign_slot0", out_inst[31:0], NOP);
        step();
        out_ready = 1;
        step();
        out_ready = 0;

        // ibar serialisation
        set_pkt(32'h1C00_0000, 2'b01, 1'b0);
        in_valid = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("ibar_mask", out_mask, 2'b01);
        chk("ibar_kill", fetch_kill, 1);
        chk("ibar_in_ready", in_ready, 0);
        step();
        ex_ser_ack = 1;
        step();
        ex_ser_ack = 0;
        @(negedge clk);
        chk("ibar_wait_kill", fetch_kill, 0);
        chk("ibar_wait_redir", redirect_valid, 0);
        step();
        icache_idle = 1; dcache_idle = 1;
        step();
        @(negedge clk);
        chk("ibar_redir", redirect_valid, 1);
        chk("ibar_redir_pc", redirect_pc, 32'h1C00_0004);
        step();
        @(negedge clk);
        chk("ibar_redir_once", redirect_valid, 0);
        step();
        icache_idle = 0; dcache_idle = 0;
        out_ready = 1;
        repeat (2) step();
        out_ready = 0;

        // csr serialisation with a late csr_done
        set_pkt(32'h1C00_0010, 2'b10, 1'b1);
        in_valid = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("csr_mask", out_mask, 2'b11);
        step();
        ex_ser_ack = 1;
        step();
        ex_ser_ack = 0;
        out_ready = 1;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            chk("csr_hold_redir", redirect_valid, 0);
            chk("csr_hold_ready", in_ready, 0);
            step();
        end
        csr_done = 1;
        step();
        csr_done = 0;
        @(negedge clk);
        chk("csr_redir", redirect_valid, 1);
        chk("csr_redir_pc", redirect_pc, 32'h1C00_0018);
        step();
        out_ready = 0;

        // Flush together with push and pop at count 3
        for (int k = 0; k < 3; k++) begin
            set_pkt(32'h300 + 8 * k, 2'b00, 1'b0);
            in_valid = 1;
            step();
        end
        set_pkt(32'h400, 2'b00, 1'b0);
        in_valid = 1; out_ready = 1; flush = 1;
        @(negedge clk);
        chk("pre_flush_count", count, 3);
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 0; in_valid = 0; out_ready = 0;
        @(negedge clk);
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_pc", out_pc, PCR);
        chk("flush_in_ready", in_ready, 1);
        step();

        // Async reset in WAIT_TLB_OK
        set_pkt(32'h1C00_0020, 2'b11, 1'b1);
        in_valid = 1;
        step();
        in_valid = 0;
        ex_ser_ack = 1;
        step();
        ex_ser_ack = 0;
        repeat (3) step();
        @(negedge clk);
        chk("tlb_wait_ready", in_ready, 0);
        chk("tlb_wait_count", count, 1);
        #2 rstn = 0;
        #1;
        chk("async_count", count, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_fetch_kill", fetch_kill, 0);
        chk("async_redirect", redirect_valid, 0);
        chk("async_out_pc", out_pc, PCR);
        chk("async_out_inst", out_inst, nop_pair);
        chk("async_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rstn = 1;

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            set_pkt({8'h1C, 22'($urandom()), 2'b00},
                    ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    1'($urandom()));
            in_valid    = $urandom_range(0, 9) < 7;
            out_ready   = $urandom_range(0, 9) < 6;
            ex_ser_ack  = $urandom_range(0, 3) == 0;
            icache_idle = $urandom_range(0, 2) != 0;
            dcache_idle = $urandom_range(0, 2) != 0;
            csr_done    = $urandom_range(0, 3) == 0;
            tlb_done    = $urandom_range(0, 3) == 0;
            flush       = $urandom_range(0, 39) == 0;
            step();
        end
        idle_in();
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
